// File: rtl/id_scoreboard.sv
// Per-register latency scoreboard for the decode stage: flags RAW/WAW hazards
// against in-flight variable-latency producers and counts stall cycles.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LW    = 3,
  parameter int EXTRA = 0,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rn,
  input  logic            id_wreg,
  input  logic [LW-1:0]   id_lat,
  input  logic            kill,
  output logic            nostall,
  output logic            id_issue,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   stall_cnt
);

  localparam int LMAX = (1 << LW) - 1;

  logic [LW-1:0] r_cnt [NREG];
  logic [CW-1:0] r_stallCnt;

  logic [LW-1:0] w_lat;
  logic          w_rawA;
  logic          w_rawB;
  logic          w_waw;
  logic          w_hazard;

  // A zero latency stays zero so ALU results never pick up the no-forwarding penalty.
  always_comb begin
    w_lat = '0;
    if (id_lat != '0) begin
      if (int'(id_lat) + EXTRA > LMAX)
        w_lat = LW'(LMAX);
      else
        w_lat = LW'(int'(id_lat) + EXTRA);
    end
  end

  always_comb begin
    w_rawA   = id_rs_used && (id_rs != '0) && (r_cnt[id_rs] != '0);
    w_rawB   = id_rt_used && (id_rt != '0) && (r_cnt[id_rt] != '0);
    w_waw    = id_wreg && (id_rn != '0) && (r_cnt[id_rn] > w_lat);
    w_hazard = id_valid && !kill && (w_rawA || w_rawB || w_waw);
    nostall  = !w_hazard;
    id_issue = id_valid && !kill && !w_hazard;
  end

  // A new issue to a register replaces its pending count rather than decrementing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        r_cnt[r] <= '0;
      r_stallCnt <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (id_issue && id_wreg && (id_rn == AW'(r)))
          r_cnt[r] <= w_lat;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - LW'(1);
      end
      if (w_hazard && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + CW'(1);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy[r] = (r_cnt[r] != '0);
  end

  assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: stimulus pushes expected per-cycle outputs
// into a queue; a negedge monitor pops and compares them.
module tb_id_scoreboard;

  typedef struct {
    string  name;
    bit     sel;
    int     ns;
    int     iss;
    longint busy;
    int     sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        idValid = 1'b0;
  logic [4:0]  idRs = '0;
  logic [4:0]  idRt = '0;
  logic        idRsUsed = 1'b0;
  logic        idRtUsed = 1'b0;
  logic [4:0]  idRn = '0;
  logic        idWreg = 1'b0;
  logic [2:0]  idLat = '0;
  logic        kill = 1'b0;

  logic        nsA, issA, nsB, issB;
  logic [31:0] busyA, busyB;
  logic [15:0] scA;
  logic [1:0]  scB;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;

  id_scoreboard dutA (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .id_rn(idRn), .id_wreg(idWreg),
    .id_lat(idLat), .kill(kill), .nostall(nsA), .id_issue(issA), .busy(busyA),
    .stall_cnt(scA)
  );

  id_scoreboard #(.EXTRA(2), .CW(2)) dutB (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .id_rn(idRn), .id_wreg(idWreg),
    .id_lat(idLat), .kill(kill), .nostall(nsB), .id_issue(issB), .busy(busyB),
    .stall_cnt(scB)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(string nm, bit sel, int ns, int iss, longint bsy, int sc);
    exp_t e;
    e.name = nm; e.sel = sel; e.ns = ns; e.iss = iss; e.busy = bsy; e.sc = sc;
    return e;
  endfunction

  function automatic longint bitOf(int r);
    return longint'(1) << r;
  endfunction

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // A field of -1 in an expectation means that field is not checked this cycle.
  task automatic checkOutput(input exp_t e);
    logic        ns, iss;
    logic [31:0] bsy;
    logic [15:0] sc;
    ns  = e.sel ? nsB   : nsA;
    iss = e.sel ? issB  : issA;
    bsy = e.sel ? busyB : busyA;
    sc  = e.sel ? {14'd0, scB} : scA;
    if (e.ns   >= 0) cmp({e.name, ".nostall"},   {31'd0, ns},  32'(e.ns));
    if (e.iss  >= 0) cmp({e.name, ".id_issue"},  {31'd0, iss}, 32'(e.iss));
    if (e.busy >= 0) cmp({e.name, ".busy"},      bsy,          32'(e.busy));
    if (e.sc   >= 0) cmp({e.name, ".stall_cnt"}, {16'd0, sc},  32'(e.sc));
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0)
      checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input bit r, input bit v, input int rs, input bit rsU,
                               input int rt, input bit rtU, input int rn, input bit wr,
                               input int lat, input bit k, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; idValid = v;
    idRs = 5'(rs); idRsUsed = rsU; idRt = 5'(rt); idRtUsed = rtU;
    idRn = 5'(rn); idWreg = wr; idLat = 3'(lat); kill = k;
    expQ.push_back(e);
  endtask

  task automatic idle(input exp_t e);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endtask

  initial begin
    // Load-use on the default build
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E("rst", 0, -1, -1, -1, -1));
    applyStimulus(0, 1, 2, 1, 0, 0, 8, 1, 1, 0, E("lu_lw", 0, 1, 1, 0, 0));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("lu_stall", 0, 0, 0, bitOf(8), 0));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("lu_issue", 0, 1, 1, 0, 1));
    idle(E("lu_idle", 0, 1, 0, 0, 1));

    // Multiply chain, then again with an independent op in the shadow
    applyStimulus(0, 1, 2, 1, 3, 1, 5, 1, 3, 0, E("mul_issue", 0, 1, 1, 0, 1));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul_st1", 0, 0, 0, bitOf(5), 1));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul_st2", 0, 0, 0, bitOf(5), 2));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul_st3", 0, 0, 0, bitOf(5), 3));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul_go", 0, 1, 1, 0, 4));
    applyStimulus(0, 1, 2, 1, 3, 1, 5, 1, 3, 0, E("mul2_issue", 0, 1, 1, 0, 4));
    applyStimulus(0, 1, 1, 1, 2, 1, 6, 1, 0, 0, E("indep", 0, 1, 1, bitOf(5), 4));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul2_st1", 0, 0, 0, bitOf(5), 4));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul2_st2", 0, 0, 0, bitOf(5), 5));
    applyStimulus(0, 1, 5, 1, 1, 1, 10, 1, 0, 0, E("mul2_go", 0, 1, 1, 0, 6));

    // WAW: ALU write to r4 meets the mult counter at 2
    applyStimulus(0, 1, 2, 1, 3, 1, 4, 1, 3, 0, E("waw_mul", 0, 1, 1, 0, 6));
    idle(E("waw_gap", 0, 1, 0, bitOf(4), 6));
    applyStimulus(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, E("waw_st1", 0, 0, 0, bitOf(4), 6));
    applyStimulus(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, E("waw_st2", 0, 0, 0, bitOf(4), 7));
    applyStimulus(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, E("waw_go", 0, 1, 1, 0, 8));
    idle(E("waw_clr", 0, 1, 0, 0, 8));

    // Equal-latency rewrite is no WAW hazard and reloads the counter
    applyStimulus(0, 1, 2, 1, 3, 1, 11, 1, 3, 0, E("weq_a", 0, 1, 1, 0, 8));
    applyStimulus(0, 1, 1, 1, 2, 1, 11, 1, 3, 0, E("weq_b", 0, 1, 1, bitOf(11), 8));
    idle(E("weq_c3", 0, 1, 0, bitOf(11), 8));
    idle(E("weq_c2", 0, 1, 0, bitOf(11), 8));
    idle(E("weq_c1", 0, 1, 0, bitOf(11), 8));
    idle(E("weq_c0", 0, 1, 0, 0, 8));

    // r0 never tracked; kill masks a hazard
    applyStimulus(0, 1, 2, 1, 0, 0, 0, 1, 1, 0, E("r0_lw", 0, 1, 1, 0, 8));
    applyStimulus(0, 1, 0, 1, 0, 1, 9, 1, 0, 0, E("r0_use", 0, 1, 1, 0, 8));
    applyStimulus(0, 1, 2, 1, 0, 0, 12, 1, 1, 0, E("k_lw", 0, 1, 1, 0, 8));
    applyStimulus(0, 1, 12, 1, 1, 1, 9, 1, 0, 1, E("k_kill", 0, 1, 0, bitOf(12), 8));
    idle(E("k_after", 0, 1, 0, 0, 8));

    // Reset on the second stall cycle
    applyStimulus(0, 1, 2, 1, 3, 1, 7, 1, 5, 0, E("rs_mul", 0, 1, 1, 0, 8));
    applyStimulus(0, 1, 7, 1, 1, 1, 9, 1, 0, 0, E("rs_st1", 0, 0, 0, bitOf(7), 8));
    applyStimulus(1, 1, 7, 1, 1, 1, 9, 1, 0, 0, E("rs_st2", 0, 0, 0, bitOf(7), 9));
    applyStimulus(0, 1, 7, 1, 1, 1, 9, 1, 0, 0, E("rs_go", 0, 1, 1, 0, 0));

    // EXTRA=2, CW=2 build
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E("rstB", 1, -1, -1, -1, -1));
    applyStimulus(0, 1, 2, 1, 0, 0, 8, 1, 1, 0, E("x_lw", 1, 1, 1, 0, 0));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_st1", 1, 0, 0, bitOf(8), 0));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_st2", 1, 0, 0, bitOf(8), 1));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_st3", 1, 0, 0, bitOf(8), 2));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_go", 1, 1, 1, 0, 3));
    applyStimulus(0, 1, 2, 1, 0, 0, 8, 1, 1, 0, E("x_lw2", 1, 1, 1, 0, 3));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_sat1", 1, 0, 0, bitOf(8), 3));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_sat2", 1, 0, 0, bitOf(8), 3));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_sat3", 1, 0, 0, bitOf(8), 3));
    applyStimulus(0, 1, 8, 1, 1, 1, 9, 1, 0, 0, E("x_go2", 1, 1, 1, 0, 3));
    applyStimulus(0, 1, 2, 1, 3, 1, 13, 1, 7, 0, E("x_l7", 1, 1, 1, 0, 3));
    for (int i = 0; i < 7; i++)
      idle(E($sformatf("x_l7_busy%0d", i), 1, 1, 0, bitOf(13), 3));
    idle(E("x_l7_clr", 1, 1, 0, 0, 3));

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
